// File: rtl/nibble_add_seq.sv
// nibble_add_seq: serial A+B reusing one 4-bit ripple slice per nibble, LSB first; macro NIBBLE_ADD_SUB_EN adds port sub (A-B)
module fulladder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_add_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;
   assign c[0] = ci;
   assign co   = c[4];
   for (genvar i = 0; i < 4; i++) begin : g_fa
      fulladder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
   end
endmodule

module nibble_add_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
`ifdef NIBBLE_ADD_SUB_EN
   input  logic                 sub,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] S,
   output logic                 Co
);
   localparam int W = 4 * NIBBLES;
   localparam int IW = (W > 4) ? $clog2(W) : 2;
   localparam logic [3:0] LAST = 4'(NIBBLES - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic          carry;
   logic [3:0]    idx;
   logic [IW-1:0] base;
   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [3:0]    sum;
   logic          cout;
   logic          init_c;
   assign base  = IW'({idx, 2'b00});
   assign a_nib = a_r[base +: 4];
`ifdef NIBBLE_ADD_SUB_EN
   logic sub_r;
   assign b_nib  = b_r[base +: 4] ^ {4{sub_r}};
   assign init_c = sub;
`else
   assign b_nib  = b_r[base +: 4];
   assign init_c = 1'b0;
`endif
   nibble_add_slice u_slice (.a(a_nib), .b(b_nib), .ci(carry), .s(sum), .co(cout));
   // FSM: accept operands in IDLE, add one nibble per RUN cycle, hold result in DONE until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         S         <= '0;
         Co        <= 1'b0;
         carry     <= 1'b0;
         idx       <= '0;
         a_r       <= '0;
         b_r       <= '0;
`ifdef NIBBLE_ADD_SUB_EN
         sub_r     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r      <= A;
               b_r      <= B;
`ifdef NIBBLE_ADD_SUB_EN
               sub_r    <= sub;
`endif
               carry    <= init_c;
               idx      <= '0;
               S        <= '0;
               Co       <= 1'b0;
               in_ready <= 1'b0;
               state    <= RUN;
            end
            RUN: begin
               S[base +: 4] <= sum;
               carry        <= cout;
               idx          <= idx + 4'd1;
               if (idx == LAST) begin
                  Co        <= cout;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: scoreboard bench for a 4-nibble and a 1-nibble nibble_add_seq instance
module tb_nibble_add_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid0, in_ready0, out_valid0, out_ready0, Co0;
   logic [15:0] A0, B0, S0;
   logic        in_valid1, in_ready1, out_valid1, out_ready1, Co1;
   logic [3:0]  A1, B1, S1;
`ifdef NIBBLE_ADD_SUB_EN
   logic        sub0 = 1'b0;
   logic        sub1 = 1'b0;
`endif
   int          checks = 0;
   int          errors = 0;
   logic [16:0] q0[$];
   logic [4:0]  q1[$];
   int          e0 = 0;
   int          e1 = 0;
   bit          t0 = 1'b0;
   bit          t1 = 1'b0;

   always #5 clk = ~clk;

   nibble_add_seq #(.NIBBLES(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .A(A0), .B(B0),
`ifdef NIBBLE_ADD_SUB_EN
      .sub(sub0),
`endif
      .out_valid(out_valid0), .out_ready(out_ready0), .S(S0), .Co(Co0)
   );

   nibble_add_seq #(.NIBBLES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .A(A1), .B(B1),
`ifdef NIBBLE_ADD_SUB_EN
      .sub(sub1),
`endif
      .out_valid(out_valid1), .out_ready(out_ready1), .S(S1), .Co(Co1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // monitor for u0: latency counted with the accept edge as edge 1
   always @(negedge clk) begin
      if (!rst_n) begin
         q0.delete();
         t0 = 1'b0;
      end else begin
         if (t0) e0++;
         if (t0 && out_valid0) begin
            chk("u0 latency", e0, 5);
            t0 = 1'b0;
         end
         if (out_valid0) begin
            chk("u0 in_ready in DONE", {31'd0, in_ready0}, 0);
            if (q0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL u0 unexpected result: S=%0h Co=%0b, required no output", S0, Co0);
            end else begin
               chk("u0 S", {16'd0, S0}, {16'd0, q0[0][16:1]});
               chk("u0 Co", {31'd0, Co0}, {31'd0, q0[0][0]});
               if (out_ready0) void'(q0.pop_front());
            end
         end
         if (in_valid0 && in_ready0) begin
            t0 = 1'b1;
            e0 = 0;
         end
      end
   end

   // monitor for u1
   always @(negedge clk) begin
      if (!rst_n) begin
         q1.delete();
         t1 = 1'b0;
      end else begin
         if (t1) e1++;
         if (t1 && out_valid1) begin
            chk("u1 latency", e1, 2);
            t1 = 1'b0;
         end
         if (out_valid1) begin
            chk("u1 in_ready in DONE", {31'd0, in_ready1}, 0);
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL u1 unexpected result: S=%0h Co=%0b, required no output", S1, Co1);
            end else begin
               chk("u1 S", {28'd0, S1}, {28'd0, q1[0][4:1]});
               chk("u1 Co", {31'd0, Co1}, {31'd0, q1[0][0]});
               if (out_ready1) void'(q1.pop_front());
            end
         end
         if (in_valid1 && in_ready1) begin
            t1 = 1'b1;
            e1 = 0;
         end
      end
   end

   task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic [15:0] es, input logic eco, input int hold);
      int n;
      n = 0;
      while (!in_ready0 && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready0) begin
         checks++;
         errors++;
         $display("FAIL u0 accept timeout: in_ready=0, required 1");
         return;
      end
      A0 = a;
      B0 = b;
      in_valid0 = 1'b1;
      out_ready0 = (hold == 0);
      q0.push_back({es, eco});
      @(posedge clk); #1;
      if (hold > 0) begin
         A0 = 16'hAAAA;
         B0 = 16'h5555;
      end else in_valid0 = 1'b0;
      n = 0;
      while (!out_valid0 && n < 50) begin @(posedge clk); #1; n++; end
      if (!out_valid0) begin
         checks++;
         errors++;
         $display("FAIL u0 result timeout: out_valid=0, required 1");
         in_valid0 = 1'b0;
         out_ready0 = 1'b1;
         return;
      end
      repeat (hold) begin @(posedge clk); #1; end
      in_valid0 = 1'b0;
      out_ready0 = 1'b1;
      @(posedge clk); #1;
      chk("u0 idle in_ready", {31'd0, in_ready0}, 1);
      chk("u0 idle out_valid", {31'd0, out_valid0}, 0);
   endtask

   task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] es, input logic eco, input int hold);
      int n;
      n = 0;
      while (!in_ready1 && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready1) begin
         checks++;
         errors++;
         $display("FAIL u1 accept timeout: in_ready=0, required 1");
         return;
      end
      A1 = a;
      B1 = b;
      in_valid1 = 1'b1;
      out_ready1 = (hold == 0);
      q1.push_back({es, eco});
      @(posedge clk); #1;
      if (hold > 0) begin
         A1 = 4'hC;
         B1 = 4'h3;
      end else in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 50) begin @(posedge clk); #1; n++; end
      if (!out_valid1) begin
         checks++;
         errors++;
         $display("FAIL u1 result timeout: out_valid=0, required 1");
         in_valid1 = 1'b0;
         out_ready1 = 1'b1;
         return;
      end
      repeat (hold) begin @(posedge clk); #1; end
      in_valid1 = 1'b0;
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      chk("u1 idle in_ready", {31'd0, in_ready1}, 1);
      chk("u1 idle out_valid", {31'd0, out_valid1}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      in_valid0 = 1'b0; out_ready0 = 1'b1; A0 = '0; B0 = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; A1 = '0; B1 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset u0 in_ready", {31'd0, in_ready0}, 1);
      chk("reset u0 out_valid", {31'd0, out_valid0}, 0);
      chk("reset u0 S", {16'd0, S0}, 0);
      chk("reset u0 Co", {31'd0, Co0}, 0);
      chk("reset u1 in_ready", {31'd0, in_ready1}, 1);
      chk("reset u1 out_valid", {31'd0, out_valid1}, 0);
      op0(16'h1234, 16'h4321, 16'h5555, 1'b0, 0);
      op0(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0);
      op0(16'h00FF, 16'h0001, 16'h0100, 1'b0, 10);
      A0 = 16'h1234;
      B0 = 16'h4321;
      in_valid0 = 1'b1;
      q0.push_back({16'h5555, 1'b0});
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrun reset out_valid", {31'd0, out_valid0}, 0);
      chk("midrun reset S", {16'd0, S0}, 0);
      chk("midrun reset Co", {31'd0, Co0}, 0);
      chk("midrun reset in_ready", {31'd0, in_ready0}, 1);
      op0(16'h0003, 16'h0004, 16'h0007, 1'b0, 0);
      op0(16'h8000, 16'h8000, 16'h0000, 1'b1, 0);
      op0(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 0);
      op0(16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 0);
`ifdef NIBBLE_ADD_SUB_EN
      sub0 = 1'b1;
      op0(16'h0005, 16'h0007, 16'hFFFE, 1'b0, 0);
      op0(16'h0007, 16'h0005, 16'h0002, 1'b1, 0);
      sub0 = 1'b0;
      op0(16'h0001, 16'h0001, 16'h0002, 1'b0, 0);
`endif
      op1(4'h9, 4'h8, 4'h1, 1'b1, 0);
      op1(4'hF, 4'hF, 4'hE, 1'b1, 0);
      op1(4'h3, 4'h4, 4'h7, 1'b0, 0);
      op1(4'hA, 4'h5, 4'hF, 1'b0, 3);
      repeat (5) @(posedge clk);
      #1;
      chk("u0 scoreboard drained", q0.size(), 0);
      chk("u1 scoreboard drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
